// File: rtl/onchip_mem_stream_reader.sv
// onchip_mem_stream_reader
// Reads a contiguous, optionally looping, range of wide words from on-chip
// memory and emits each word as a sequence of narrow samples on a
// ready/valid stream with start/end-of-pass markers.
module onchip_mem_stream_reader #(
  parameter int ADDR_WIDTH   = 12,
  parameter int DEPTH        = 4000,
  parameter int DATA_WIDTH   = 256,
  parameter int SAMPLE_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [ADDR_WIDTH-1:0]   start_addr,
  input  logic [ADDR_WIDTH:0]     word_count,
  input  logic                    loop,
  input  logic                    stop,
  output logic                    busy,
  output logic                    done,
  output logic [ADDR_WIDTH-1:0]   mem_address,
  output logic                    mem_chipselect,
  output logic                    mem_clken,
  input  logic [DATA_WIDTH-1:0]   mem_readdata,
  output logic [SAMPLE_WIDTH-1:0] src_data,
  output logic                    src_valid,
  input  logic                    src_ready,
  output logic                    src_startofpacket,
  output logic                    src_endofpacket
);

  localparam int LANES = DATA_WIDTH / SAMPLE_WIDTH;
  localparam int IDX_W = $clog2(LANES);

  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, EMIT} state_t;

  state_t                  state_reg;
  logic [ADDR_WIDTH-1:0]   addr_reg;
  logic [ADDR_WIDTH-1:0]   start_addr_reg;
  logic [ADDR_WIDTH:0]     count_reg;
  logic [ADDR_WIDTH:0]     remaining_reg;
  logic                    loop_reg;
  logic [DATA_WIDTH-1:0]   buffer_reg;
  logic [IDX_W-1:0]        idx_reg;

  logic [SAMPLE_WIDTH-1:0] lanes [LANES];
  logic [IDX_W-1:0]        idx_next;
  logic [ADDR_WIDTH-1:0]   addr_next;
  logic                    last_lane;
  logic                    last_word;
  logic                    first_word;

  // Split the captured word into sample lanes; lane 0 is the least significant.
  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      assign lanes[gi] = buffer_reg[gi*SAMPLE_WIDTH +: SAMPLE_WIDTH];
    end
  endgenerate

  // Lane/word bookkeeping and wrap-around address increment.
  always_comb begin
    idx_next   = idx_reg + 1'b1;
    last_lane  = (idx_reg == IDX_W'(LANES - 1));
    last_word  = (remaining_reg == (ADDR_WIDTH+1)'(1));
    first_word = (remaining_reg == count_reg);
    addr_next  = (addr_reg == ADDR_WIDTH'(DEPTH - 1)) ? '0 : addr_reg + 1'b1;
  end

  // Control FSM with all outputs registered.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg         <= IDLE;
      addr_reg          <= '0;
      start_addr_reg    <= '0;
      count_reg         <= '0;
      remaining_reg     <= '0;
      loop_reg          <= 1'b0;
      buffer_reg        <= '0;
      idx_reg           <= '0;
      busy              <= 1'b0;
      done              <= 1'b0;
      mem_address       <= '0;
      mem_chipselect    <= 1'b0;
      mem_clken         <= 1'b0;
      src_data          <= '0;
      src_valid         <= 1'b0;
      src_startofpacket <= 1'b0;
      src_endofpacket   <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state_reg != IDLE && stop) begin
        // Abort: drop any read in flight and any undelivered samples.
        state_reg         <= IDLE;
        busy              <= 1'b0;
        done              <= 1'b1;
        mem_chipselect    <= 1'b0;
        mem_clken         <= 1'b0;
        src_valid         <= 1'b0;
        src_startofpacket <= 1'b0;
        src_endofpacket   <= 1'b0;
      end else begin
        case (state_reg)
          IDLE: begin
            if (start) begin
              start_addr_reg <= start_addr;
              count_reg      <= word_count;
              loop_reg       <= loop;
              if (word_count == '0) begin
                done <= 1'b1;
              end else begin
                state_reg      <= ISSUE;
                busy           <= 1'b1;
                addr_reg       <= start_addr;
                remaining_reg  <= word_count;
                mem_address    <= start_addr;
                mem_chipselect <= 1'b1;
                mem_clken      <= 1'b1;
              end
            end
          end
          ISSUE: begin
            // The read request is held for exactly one cycle.
            mem_chipselect <= 1'b0;
            mem_clken      <= 1'b0;
            state_reg      <= CAPTURE;
          end
          CAPTURE: begin
            buffer_reg        <= mem_readdata;
            idx_reg           <= '0;
            src_valid         <= 1'b1;
            src_data          <= mem_readdata[SAMPLE_WIDTH-1:0];
            src_startofpacket <= first_word;
            src_endofpacket   <= 1'b0;
            state_reg         <= EMIT;
          end
          EMIT: begin
            if (src_ready) begin
              if (!last_lane) begin
                idx_reg           <= idx_next;
                src_data          <= lanes[idx_next];
                src_startofpacket <= 1'b0;
                src_endofpacket   <= (idx_next == IDX_W'(LANES - 1)) && last_word;
              end else begin
                src_valid         <= 1'b0;
                src_startofpacket <= 1'b0;
                src_endofpacket   <= 1'b0;
                if (!last_word) begin
                  remaining_reg  <= remaining_reg - 1'b1;
                  addr_reg       <= addr_next;
                  mem_address    <= addr_next;
                  mem_chipselect <= 1'b1;
                  mem_clken      <= 1'b1;
                  state_reg      <= ISSUE;
                end else if (loop_reg) begin
                  // Restart the pass with the same gap as between words.
                  remaining_reg  <= count_reg;
                  addr_reg       <= start_addr_reg;
                  mem_address    <= start_addr_reg;
                  mem_chipselect <= 1'b1;
                  mem_clken      <= 1'b1;
                  state_reg      <= ISSUE;
                end else begin
                  state_reg <= IDLE;
                  busy      <= 1'b0;
                  done      <= 1'b1;
                end
              end
            end
          end
          default: state_reg <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_onchip_mem_stream_reader.sv
// Scoreboard bench for onchip_mem_stream_reader: stimulus pushes expected
// samples/addresses, a negedge monitor pops and compares them.
module tb_onchip_mem_stream_reader;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic [11:0]  start_addr = '0;
  logic [12:0]  word_count = '0;
  logic         loop = 1'b0;
  logic         stop = 1'b0;
  logic         busy, done;
  logic [11:0]  mem_address;
  logic         mem_chipselect, mem_clken;
  logic [255:0] mem_readdata = '0;
  logic [31:0]  src_data;
  logic         src_valid;
  logic         src_ready = 1'b0;
  logic         src_startofpacket, src_endofpacket;

  onchip_mem_stream_reader dut (
    .clk(clk), .reset(reset), .start(start), .start_addr(start_addr),
    .word_count(word_count), .loop(loop), .stop(stop), .busy(busy), .done(done),
    .mem_address(mem_address), .mem_chipselect(mem_chipselect), .mem_clken(mem_clken),
    .mem_readdata(mem_readdata), .src_data(src_data), .src_valid(src_valid),
    .src_ready(src_ready), .src_startofpacket(src_startofpacket),
    .src_endofpacket(src_endofpacket)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Memory model: word k holds samples k*8+7 .. k*8, one-cycle read latency.
  function automatic logic [255:0] make_word(input logic [11:0] a);
    logic [255:0] w;
    for (int l = 0; l < 8; l++) w[l*32 +: 32] = 32'(a) * 32'd8 + 32'(l);
    return w;
  endfunction

  always @(posedge clk)
    if (mem_chipselect && mem_clken) mem_readdata <= make_word(mem_address);

  logic [33:0] exp_q[$];
  logic [11:0] addr_q[$];
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor state
  int          xfer_cnt = 0, done_cnt = 0, busy_cnt = 0, access_cnt = 0;
  int          first_valid_cyc = -1, last_xfer_cyc = -1, done_cyc = -1;
  logic        prev_stall = 1'b0;
  logic [31:0] prev_data = '0;
  logic [33:0] mon_e;
  logic [11:0] mon_a;

  always @(negedge clk) begin
    if (!reset) begin
      if (src_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (prev_stall && src_valid) check("stall_stable", 64'(src_data), 64'(prev_data));
      prev_stall = src_valid && !src_ready;
      prev_data  = src_data;
      if (src_valid && src_ready) begin
        if (exp_q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL sample_unexpected: got %0d expected none", src_data);
        end else begin
          mon_e = exp_q.pop_front();
          check("sample_data", 64'(src_data), 64'(mon_e[31:0]));
          check("sop", 64'(src_startofpacket), 64'(mon_e[33]));
          check("eop", 64'(src_endofpacket), 64'(mon_e[32]));
        end
        xfer_cnt++;
        last_xfer_cyc = cyc;
      end
      if (mem_chipselect) begin
        access_cnt++;
        if (addr_q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL mem_access_unexpected: got %0d expected none", mem_address);
        end else begin
          mon_a = addr_q.pop_front();
          check("mem_address", 64'(mem_address), 64'(mon_a));
          check("mem_clken", 64'(mem_clken), 64'd1);
        end
      end
      if (done) begin done_cnt++; done_cyc = cyc; end
      if (busy) busy_cnt++;
    end else begin
      prev_stall = 1'b0;
    end
  end

  // Optional random backpressure
  logic rand_ready = 1'b0;
  always @(posedge clk)
    if (rand_ready) begin
      #1;
      src_ready = 1'($urandom_range(0, 1));
    end

  int start_cyc = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_pass(input int a, input int wc);
    for (int w = 0; w < wc; w++) begin
      int aa;
      aa = (a + w) % 4000;
      addr_q.push_back(12'(aa));
      for (int l = 0; l < 8; l++)
        exp_q.push_back({(w == 0 && l == 0), (w == wc - 1 && l == 7), 32'(aa * 8 + l)});
    end
  endtask

  task automatic do_start(input int a, input int wc, input logic lp);
    start_addr = 12'(a);
    word_count = 13'(wc);
    loop       = lp;
    start      = 1'b1;
    start_cyc  = cyc;
    tick();
    start      = 1'b0;
  endtask

  task automatic wait_done(input int prev, input int limit);
    int k;
    k = 0;
    while (done_cnt == prev && k < limit) begin
      tick();
      k++;
    end
    check("done_within_bound", 64'(done_cnt > prev), 64'd1);
    tick();
    tick();
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_done"}, 64'(done), 64'd0);
    check({tag, "_mem_address"}, 64'(mem_address), 64'd0);
    check({tag, "_chipselect"}, 64'(mem_chipselect), 64'd0);
    check({tag, "_clken"}, 64'(mem_clken), 64'd0);
    check({tag, "_src_valid"}, 64'(src_valid), 64'd0);
    check({tag, "_src_data"}, 64'(src_data), 64'd0);
    check({tag, "_sop"}, 64'(src_startofpacket), 64'd0);
    check({tag, "_eop"}, 64'(src_endofpacket), 64'd0);
  endtask

  initial begin : watchdog
    #2ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int d0, a0, x0, k;
    repeat (3) tick();
    check_idle_outputs("reset");
    reset = 1'b0;
    tick();

    // Basic pass: 3 words from address 5, sink always ready.
    src_ready = 1'b1;
    d0 = done_cnt; a0 = access_cnt;
    first_valid_cyc = -1; busy_cnt = 0;
    push_pass(5, 3);
    do_start(5, 3, 1'b0);
    wait_done(d0, 100);
    check("first_valid_latency", 64'(first_valid_cyc - start_cyc), 64'd3);
    check("done_after_last", 64'(done_cyc - last_xfer_cyc), 64'd1);
    check("busy_cycles", 64'(busy_cnt), 64'd30);
    check("done_single_pulse", 64'(done_cnt - d0), 64'd1);
    check("basic_queue_empty", 64'(exp_q.size()), 64'd0);
    check("basic_accesses", 64'(access_cnt - a0), 64'd3);
    $display("[TB] basic pass: %0d samples", xfer_cnt);

    // Address wrap at the top of memory.
    d0 = done_cnt;
    push_pass(3998, 3);
    do_start(3998, 3, 1'b0);
    wait_done(d0, 100);
    check("wrap_queue_empty", 64'(exp_q.size()), 64'd0);
    check("wrap_addr_queue_empty", 64'(addr_q.size()), 64'd0);
    $display("[TB] wrap pass done");

    // Random backpressure.
    d0 = done_cnt;
    rand_ready = 1'b1;
    push_pass(5, 3);
    do_start(5, 3, 1'b0);
    wait_done(d0, 1000);
    rand_ready = 1'b0;
    tick();
    src_ready = 1'b1;
    check("stall_queue_empty", 64'(exp_q.size()), 64'd0);
    $display("[TB] backpressure pass done");

    // Loop mode, stopped in the middle of the third pass.
    d0 = done_cnt; a0 = access_cnt; x0 = xfer_cnt;
    push_pass(10, 2); push_pass(10, 2); push_pass(10, 2);
    do_start(10, 2, 1'b1);
    k = 0;
    while (xfer_cnt < x0 + 37 && k < 200) begin tick(); k++; end
    check("loop_reach_third_pass", 64'(xfer_cnt - x0), 64'd37);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check("stop_valid_low", 64'(src_valid), 64'd0);
    check("stop_busy_low", 64'(busy), 64'd0);
    check("stop_done_high", 64'(done), 64'd1);
    check("loop_no_done", 64'(done_cnt - d0), 64'd0);
    tick();
    check("stop_done_pulse_end", 64'(done), 64'd0);
    check("stop_done_count", 64'(done_cnt - d0), 64'd1);
    check("stop_xfers", 64'(xfer_cnt - x0), 64'd38);
    check("stop_accesses", 64'(access_cnt - a0), 64'd5);
    exp_q.delete(); addr_q.delete();
    $display("[TB] loop/stop done");

    // Zero-length request.
    d0 = done_cnt; a0 = access_cnt;
    do_start(0, 0, 1'b0);
    check("zero_done", 64'(done), 64'd1);
    check("zero_busy", 64'(busy), 64'd0);
    tick();
    check("zero_done_end", 64'(done), 64'd0);
    check("zero_busy_stays", 64'(busy), 64'd0);
    check("zero_no_access", 64'(access_cnt - a0), 64'd0);
    $display("[TB] zero-length done");

    // Start while busy is ignored.
    d0 = done_cnt; a0 = access_cnt;
    push_pass(0, 1);
    do_start(0, 1, 1'b0);
    repeat (3) tick();
    do_start(100, 1, 1'b0);
    wait_done(d0, 100);
    repeat (12) tick();
    check("busy_start_done_count", 64'(done_cnt - d0), 64'd1);
    check("busy_start_accesses", 64'(access_cnt - a0), 64'd1);
    check("busy_start_queue_empty", 64'(exp_q.size()), 64'd0);
    $display("[TB] start-while-busy done");

    // Reset in the middle of EMIT.
    d0 = done_cnt; x0 = xfer_cnt;
    push_pass(2, 2);
    do_start(2, 2, 1'b0);
    k = 0;
    while (xfer_cnt < x0 + 3 && k < 100) begin tick(); k++; end
    check("rst_reach_emit", 64'(xfer_cnt - x0), 64'd3);
    reset = 1'b1;
    tick();
    check_idle_outputs("rst_mid");
    reset = 1'b0;
    exp_q.delete(); addr_q.delete();
    repeat (3) tick();
    check("rst_no_done", 64'(done_cnt - d0), 64'd0);
    check("rst_stays_idle", 64'(src_valid), 64'd0);
    $display("[TB] reset mid-emit done");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
